gen_ce_multi: RTL

GEN_CE_MULTI -- requirements
Module: gen_ce_multi

---
 rtl/gen_ce_multi.sv | 102 ++++++++++
 1 files changed

// File: rtl/gen_ce_multi.sv
// Mode-selectable clock-enable prescaler feeding a cascade of fixed-ratio stages.
// A full cascade carry ripples combinationally, so every stage can fire in the same cycle.

module gen_ce_stage #(
    parameter int RATIO = 10
) (
    input  logic clk,
    input  logic R_n,
    input  logic clr,
    input  logic pulse_in,
    output logic pulse_out
);
    localparam int SW = $clog2(RATIO);
    localparam logic [SW-1:0] LAST = SW'(RATIO - 1);

    logic [SW-1:0] s;

    assign pulse_out = pulse_in & (s == LAST);

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n)          s <= '0;
        else if (clr)      s <= '0;
        else if (pulse_in) s <= (s == LAST) ? '0 : s + 1'b1;
    end
endmodule

module gen_ce_multi #(
    parameter int DIV0       = 5000000,
    parameter int DIV1       = 50000000,
    parameter int DIV2       = 50000,
    parameter int DIV3       = 1,
    parameter int WIDTH      = 26,
    parameter int NUM_STAGES = 3,
    parameter int RATIO      = 10
) (
    input  logic                  clk,
    input  logic                  R_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [1:0]            mode,
    output logic                  ce_base,
    output logic [NUM_STAGES-1:0] ce_stage,
    output logic [WIDTH-1:0]      cnt,
    output logic [1:0]            mode_act
);
    localparam logic [63:0] LIM = 64'd1 << WIDTH;

    if (64'(DIV0) > LIM || 64'(DIV1) > LIM || 64'(DIV2) > LIM || 64'(DIV3) > LIM) begin : g_div_chk
        $error("gen_ce_multi: a divisor minus one does not fit in WIDTH bits");
    end
    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_stg_chk
        $error("gen_ce_multi: NUM_STAGES out of range 1..8");
    end
    if (RATIO < 2 || RATIO > 256) begin : g_ratio_chk
        $error("gen_ce_multi: RATIO out of range 2..256");
    end

    // Divisors 0 and 1 both reload zero, giving a pulse on every enabled cycle.
    function automatic logic [WIDTH-1:0] load_of(input int div);
        return (div <= 1) ? '0 : WIDTH'(div - 1);
    endfunction

    localparam logic [3:0][WIDTH-1:0] LOAD = {load_of(DIV3), load_of(DIV2),
                                              load_of(DIV1), load_of(DIV0)};

    assign ce_base = R_n & en & ~clr & (cnt == '0);

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            cnt      <= '0;
            mode_act <= 2'd0;
        end else if (clr) begin
            cnt      <= '0;
            mode_act <= mode;
        end else if (en) begin
            if (cnt == '0) begin
                cnt      <= LOAD[mode];
                mode_act <= mode;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic p_in;
        logic p_out;
        if (i == 0) begin : g_first
            assign p_in = ce_base;
        end else begin : g_next
            assign p_in = g_stage[i-1].p_out;
        end
        gen_ce_stage #(.RATIO(RATIO)) u_stage (
            .clk      (clk),
            .R_n      (R_n),
            .clr      (clr),
            .pulse_in (p_in),
            .pulse_out(p_out)
        );
        assign ce_stage[i] = p_out;
    end
endmodule
